// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - data-memory bus between the load/store unit and memory
interface mem_lsu_if #(
    parameter int AW = 32
);
    logic          req;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          ack;
    logic [31:0]   rdata;

    modport master (output req, we, be, addr, wdata, input ack, rdata);
    modport slave  (input req, we, be, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store unit with MEM/WB register, forwarding and bus timeout
module mem_lsu #(
    parameter int AW      = 32,
    parameter int DESW    = 7,
    parameter int MAXWAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic            ex_ld,
    input  logic            ex_st,
    input  logic [1:0]      ex_size,
    input  logic            ex_sign,
    input  logic [AW-1:0]   ex_addr,
    input  logic [31:0]     ex_wdata,
    input  logic [31:0]     ex_alures,
    input  logic [DESW-1:0] ex_des,
    input  logic [31:0]     ex_pc,
    mem_lsu_if.master       dmem,
    output logic            stall,
    output logic            wb_valid,
    output logic [31:0]     wb_result,
    output logic [DESW-1:0] wb_des,
    output logic [31:0]     wb_pc,
    output logic            fwd_valid,
    output logic [31:0]     fwd_result,
    output logic [DESW-1:0] fwd_des,
    output logic            exc_adel,
    output logic            exc_ades,
    output logic            exc_bus,
    output logic [AW-1:0]   exc_badvaddr,
    output logic [31:0]     exc_pc
);
    typedef enum logic {S_IDLE, S_BUS} state_t;

    localparam logic [7:0] CNT_LAST = 8'(MAXWAIT - 1);

    state_t          state, state_n;
    logic [7:0]      cnt;
    logic [AW-1:0]   l_addr;
    logic [31:0]     l_wdata;
    logic [1:0]      l_size;
    logic            l_sign;
    logic [DESW-1:0] l_des;
    logic [31:0]     l_pc;
    logic            l_st;

    logic            is_mem;
    logic            misal;
    logic            timeout;
    logic [1:0]      off;
    logic [31:0]     shifted;
    logic [31:0]     load_data;

    assign is_mem  = ex_valid & (ex_ld | ex_st);
    assign off     = l_addr[1:0];
    assign shifted = dmem.rdata >> {off, 3'b000};
    assign timeout = (state == S_BUS) & ~dmem.ack & (cnt == CNT_LAST);

    always_comb begin
        misal = 1'b0;
        case (ex_size)
            2'b00:   misal = 1'b0;
            2'b01:   misal = ex_addr[0];
            default: misal = |ex_addr[1:0];
        endcase
    end

    always_comb begin
        load_data = shifted;
        case (l_size)
            2'b00:   load_data = {{24{l_sign & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{l_sign & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        dmem.req   = (state == S_BUS);
        dmem.we    = (state == S_BUS) & l_st;
        dmem.addr  = {l_addr[AW-1:2], 2'b00};
        dmem.be    = 4'b1111;
        dmem.wdata = l_wdata;
        case (l_size)
            2'b00: begin
                dmem.be    = 4'b0001 << off;
                dmem.wdata = {4{l_wdata[7:0]}};
            end
            2'b01: begin
                dmem.be    = off[1] ? 4'b1100 : 4'b0011;
                dmem.wdata = {2{l_wdata[15:0]}};
            end
            default: begin
                dmem.be    = 4'b1111;
                dmem.wdata = l_wdata;
            end
        endcase
    end

    // Stall is masked by reset so upstream is released the instant reset hits.
    always_comb begin
        state_n    = state;
        stall      = 1'b0;
        fwd_valid  = 1'b0;
        fwd_result = '0;
        fwd_des    = '0;
        case (state)
            S_IDLE: begin
                if (is_mem && !misal) begin
                    state_n = S_BUS;
                    stall   = 1'b1;
                end else if (ex_valid && !is_mem && (ex_des != '0)) begin
                    fwd_valid  = 1'b1;
                    fwd_result = ex_alures;
                    fwd_des    = ex_des;
                end
            end
            S_BUS: begin
                stall = ~dmem.ack;
                if (dmem.ack) begin
                    state_n = S_IDLE;
                    if (!l_st) begin
                        fwd_valid  = 1'b1;
                        fwd_result = load_data;
                        fwd_des    = l_des;
                    end
                end else if (timeout) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        stall = stall & reset;
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            l_addr       <= '0;
            l_wdata      <= '0;
            l_size       <= '0;
            l_sign       <= 1'b0;
            l_des        <= '0;
            l_pc         <= '0;
            l_st         <= 1'b0;
            wb_valid     <= 1'b0;
            wb_result    <= '0;
            wb_des       <= '0;
            wb_pc        <= '0;
            exc_adel     <= 1'b0;
            exc_ades     <= 1'b0;
            exc_bus      <= 1'b0;
            exc_badvaddr <= '0;
            exc_pc       <= '0;
        end else begin
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
            exc_bus  <= 1'b0;
            case (state)
                S_IDLE: begin
                    wb_valid <= 1'b0;
                    if (is_mem) begin
                        if (misal) begin
                            exc_adel     <= ex_ld;
                            exc_ades     <= ex_st;
                            exc_badvaddr <= ex_addr;
                            exc_pc       <= ex_pc;
                        end else begin
                            cnt     <= '0;
                            l_addr  <= ex_addr;
                            l_wdata <= ex_wdata;
                            l_size  <= ex_size;
                            l_sign  <= ex_sign;
                            l_des   <= ex_des;
                            l_pc    <= ex_pc;
                            l_st    <= ex_st;
                        end
                    end else if (ex_valid) begin
                        wb_valid  <= 1'b1;
                        wb_result <= ex_alures;
                        wb_des    <= ex_des;
                        wb_pc     <= ex_pc;
                    end
                end
                S_BUS: begin
                    wb_valid <= 1'b0;
                    if (dmem.ack) begin
                        cnt <= '0;
                        if (!l_st) begin
                            wb_valid  <= 1'b1;
                            wb_result <= load_data;
                            wb_des    <= l_des;
                            wb_pc     <= l_pc;
                        end
                    end else if (timeout) begin
                        cnt          <= '0;
                        exc_bus      <= 1'b1;
                        exc_badvaddr <= l_addr;
                        exc_pc       <= l_pc;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: wb_valid <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed table-driven bench for mem_lsu
module tb_mem_lsu;
    logic        clk;
    logic        reset;
    logic        ex_valid, ex_ld, ex_st, ex_sign;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata, ex_alures, ex_pc;
    logic [6:0]  ex_des;
    logic        stall, wb_valid, fwd_valid;
    logic [31:0] wb_result, wb_pc, fwd_result, exc_badvaddr, exc_pc;
    logic [6:0]  wb_des, fwd_des;
    logic        exc_adel, exc_ades, exc_bus;

    int checks = 0;
    int errors = 0;

    mem_lsu_if #(.AW(32)) dmem ();

    mem_lsu #(.AW(32), .DESW(7), .MAXWAIT(15)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ld(ex_ld), .ex_st(ex_st), .ex_size(ex_size), .ex_sign(ex_sign),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_alures(ex_alures), .ex_des(ex_des), .ex_pc(ex_pc),
        .dmem(dmem.master), .stall(stall),
        .wb_valid(wb_valid), .wb_result(wb_result), .wb_des(wb_des), .wb_pc(wb_pc),
        .fwd_valid(fwd_valid), .fwd_result(fwd_result), .fwd_des(fwd_des),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus),
        .exc_badvaddr(exc_badvaddr), .exc_pc(exc_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid, ld, st;
        logic [1:0]  size;
        logic [31:0] addr, alures;
        logic [6:0]  des;
        logic [31:0] pc;
        logic        ack;
        logic        e_stall, e_wbv;
        logic [31:0] e_res;
        logic        e_fwd, e_adel, e_ades;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic edge_wait();
        @(negedge clk);
        #1;
    endtask

    task automatic mem_op(input logic ld, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                          input int waits, input logic [3:0] be_e, input logic [31:0] wd_e,
                          input logic [31:0] res_e, input string nm);
        int stall_cnt;
        ex_valid = 1'b1; ex_ld = ld; ex_st = ~ld; ex_size = size; ex_sign = sign;
        ex_addr = addr; ex_wdata = wdata; ex_alures = 32'hDEAD_0000; ex_des = 7'd9;
        ex_pc = 32'h8000_0000 + addr;
        #1;
        stall_cnt = 0;
        if (stall) stall_cnt++;
        chk({nm, " idle req"}, {31'd0, dmem.req}, 32'd0);
        edge_wait();
        for (int i = 0; i < waits; i++) begin
            if (stall) stall_cnt++;
            if (!dmem.req) chk({nm, " wait req"}, {31'd0, dmem.req}, 32'd1);
            edge_wait();
        end
        dmem.ack = 1'b1;
        dmem.rdata = rdata;
        #1;
        chk({nm, " req"}, {31'd0, dmem.req}, 32'd1);
        chk({nm, " we"}, {31'd0, dmem.we}, {31'd0, ~ld});
        chk({nm, " be"}, {28'd0, dmem.be}, {28'd0, be_e});
        chk({nm, " addr"}, dmem.addr, {addr[31:2], 2'b00});
        chk({nm, " ack stall"}, {31'd0, stall}, 32'd0);
        chk({nm, " fwd_valid"}, {31'd0, fwd_valid}, {31'd0, ld});
        if (ld) chk({nm, " fwd_result"}, fwd_result, res_e);
        else    chk({nm, " wdata"}, dmem.wdata, wd_e);
        edge_wait();
        dmem.ack = 1'b0;
        ex_valid = 1'b0;
        chk({nm, " stall cycles"}, stall_cnt, waits + 1);
        chk({nm, " wb_valid"}, {31'd0, wb_valid}, {31'd0, ld});
        chk({nm, " exc_bus"}, {31'd0, exc_bus}, 32'd0);
        if (ld) begin
            chk({nm, " wb_result"}, wb_result, res_e);
            chk({nm, " wb_des"}, {25'd0, wb_des}, 32'd9);
            chk({nm, " wb_pc"}, wb_pc, 32'h8000_0000 + addr);
        end
    endtask

    initial begin
        int n;
        reset = 1'b0;
        ex_valid = 0; ex_ld = 0; ex_st = 0; ex_size = 0; ex_sign = 0;
        ex_addr = 0; ex_wdata = 0; ex_alures = 0; ex_des = 0; ex_pc = 0;
        dmem.ack = 1'b0; dmem.rdata = 32'h0;

        //            v  ld st sz  addr         alures        des    pc            ack stl wbv res           fwd adl ads
        vecs[0] = '{1, 0, 0, 2'd0, 32'h0,       32'h1234,     7'd5,  32'h1000,     0,  0,  1,  32'h1234,     1,  0,  0};
        vecs[1] = '{1, 0, 0, 2'd0, 32'h0,       32'hCAFEBABE, 7'd0,  32'h1004,     0,  0,  1,  32'hCAFEBABE, 0,  0,  0};
        vecs[2] = '{0, 0, 0, 2'd0, 32'h0,       32'h7777,     7'd3,  32'h1008,     1,  0,  0,  32'h0,        0,  0,  0};
        vecs[3] = '{1, 1, 0, 2'd2, 32'h101,     32'h0,        7'd4,  32'h100C,     0,  0,  0,  32'h0,        0,  1,  0};
        vecs[4] = '{1, 0, 1, 2'd2, 32'h102,     32'h0,        7'd4,  32'h1010,     0,  0,  0,  32'h0,        0,  0,  1};
        vecs[5] = '{1, 1, 0, 2'd1, 32'h103,     32'h0,        7'd4,  32'h1014,     0,  0,  0,  32'h0,        0,  1,  0};
        vecs[6] = '{1, 0, 1, 2'd1, 32'h201,     32'h0,        7'd4,  32'h1018,     0,  0,  0,  32'h0,        0,  0,  1};
        vecs[7] = '{1, 1, 0, 2'd3, 32'h102,     32'h0,        7'd4,  32'h101C,     0,  0,  0,  32'h0,        0,  1,  0};
        vecs[8] = '{1, 0, 0, 2'd0, 32'h0,       32'h55,       7'h7F, 32'h1020,     0,  0,  1,  32'h55,       1,  0,  0};

        edge_wait();
        edge_wait();
        chk("reset req", {31'd0, dmem.req}, 32'd0);
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("reset exc", {29'd0, exc_adel, exc_ades, exc_bus}, 32'd0);
        chk("reset wb_result", wb_result, 32'd0);
        @(posedge clk);
        reset = 1'b1;
        edge_wait();

        for (int i = 0; i < 9; i++) begin
            ex_valid = vecs[i].valid; ex_ld = vecs[i].ld; ex_st = vecs[i].st;
            ex_size = vecs[i].size; ex_sign = 1'b0; ex_addr = vecs[i].addr;
            ex_alures = vecs[i].alures; ex_des = vecs[i].des; ex_pc = vecs[i].pc;
            dmem.ack = vecs[i].ack;
            #1;
            chk($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
            chk($sformatf("v%0d req", i), {31'd0, dmem.req}, 32'd0);
            chk($sformatf("v%0d fwd_valid", i), {31'd0, fwd_valid}, {31'd0, vecs[i].e_fwd});
            if (vecs[i].e_fwd) begin
                chk($sformatf("v%0d fwd_result", i), fwd_result, vecs[i].alures);
                chk($sformatf("v%0d fwd_des", i), {25'd0, fwd_des}, {25'd0, vecs[i].des});
            end
            edge_wait();
            chk($sformatf("v%0d wb_valid", i), {31'd0, wb_valid}, {31'd0, vecs[i].e_wbv});
            if (vecs[i].e_wbv) begin
                chk($sformatf("v%0d wb_result", i), wb_result, vecs[i].e_res);
                chk($sformatf("v%0d wb_des", i), {25'd0, wb_des}, {25'd0, vecs[i].des});
                chk($sformatf("v%0d wb_pc", i), wb_pc, vecs[i].pc);
            end
            chk($sformatf("v%0d exc_adel", i), {31'd0, exc_adel}, {31'd0, vecs[i].e_adel});
            chk($sformatf("v%0d exc_ades", i), {31'd0, exc_ades}, {31'd0, vecs[i].e_ades});
            chk($sformatf("v%0d exc_bus", i), {31'd0, exc_bus}, 32'd0);
            if (vecs[i].e_adel || vecs[i].e_ades) begin
                chk($sformatf("v%0d badvaddr", i), exc_badvaddr, vecs[i].addr);
                chk($sformatf("v%0d exc_pc", i), exc_pc, vecs[i].pc);
            end
        end
        ex_valid = 1'b0;
        dmem.ack = 1'b0;
        edge_wait();

        // Back-to-back memory ops, including an ack in the last allowed wait cycle.
        mem_op(1'b1, 2'd0, 1'b1, 32'h103, 32'h0,        32'h80FF_FF00, 3,  4'b1000, 32'h0,        32'hFFFF_FF80, "lb");
        mem_op(1'b0, 2'd1, 1'b0, 32'h202, 32'hABCD,     32'h0,         0,  4'b1100, 32'hABCD_ABCD, 32'h0,        "sh");
        mem_op(1'b1, 2'd1, 1'b0, 32'h102, 32'h0,        32'h8765_4321, 1,  4'b1100, 32'h0,        32'h0000_8765, "lhu");
        mem_op(1'b1, 2'd1, 1'b1, 32'h102, 32'h0,        32'h8765_4321, 0,  4'b1100, 32'h0,        32'hFFFF_8765, "lh");
        mem_op(1'b1, 2'd0, 1'b0, 32'h101, 32'h0,        32'h1234_5678, 2,  4'b0010, 32'h0,        32'h0000_0056, "lbu");
        mem_op(1'b0, 2'd0, 1'b0, 32'h203, 32'h1234_56A5, 32'h0,        1,  4'b1000, 32'hA5A5_A5A5, 32'h0,        "sb");
        mem_op(1'b0, 2'd2, 1'b0, 32'h204, 32'hDEAD_BEEF, 32'h0,        0,  4'b1111, 32'hDEAD_BEEF, 32'h0,        "sw");
        mem_op(1'b1, 2'd2, 1'b0, 32'h500, 32'h0,        32'h89AB_CDEF, 14, 4'b1111, 32'h0,        32'h89AB_CDEF, "lw_lastack");

        // Bus timeout with no ack ever returned.
        ex_valid = 1'b1; ex_ld = 1'b1; ex_st = 1'b0; ex_size = 2'd2; ex_sign = 1'b0;
        ex_addr = 32'h300; ex_des = 7'd6; ex_pc = 32'h2000;
        edge_wait();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            n++;
            edge_wait();
            if (exc_bus) break;
        end
        ex_ld = 1'b0; ex_alures = 32'h0BAD_F00D; ex_des = 7'd2; ex_pc = 32'h2004;
        chk("timeout cycles", n, 32'd15);
        chk("timeout exc_bus", {31'd0, exc_bus}, 32'd1);
        chk("timeout badvaddr", exc_badvaddr, 32'h300);
        chk("timeout exc_pc", exc_pc, 32'h2000);
        chk("timeout wb_valid", {31'd0, wb_valid}, 32'd0);
        #1;
        chk("timeout stall", {31'd0, stall}, 32'd0);
        edge_wait();
        chk("after timeout wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("after timeout wb_result", wb_result, 32'h0BAD_F00D);
        chk("after timeout exc_bus", {31'd0, exc_bus}, 32'd0);

        // Reset in the second bus cycle abandons the load.
        ex_ld = 1'b1; ex_addr = 32'h400; ex_des = 7'd8; ex_pc = 32'h3000;
        edge_wait();
        edge_wait();
        chk("pre-reset req", {31'd0, dmem.req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("reset req now", {31'd0, dmem.req}, 32'd0);
        chk("reset stall now", {31'd0, stall}, 32'd0);
        ex_valid = 1'b0;
        @(posedge clk);
        reset = 1'b1;
        edge_wait();
        chk("post-reset req", {31'd0, dmem.req}, 32'd0);
        edge_wait();
        chk("post-reset wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("post-reset exc", {29'd0, exc_adel, exc_ades, exc_bus}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
